sevenseg_scan_capture: RTL and testbench
========================================

// Module: sevenseg_scan_capture
// PURPOSE
//  Receive end of the 4-digit multiplexed seven-segment interface. Samples anode-select and
//  segment lines, waits out each digit's settle time, decodes the glyph back to a 4-bit hex
//  char and emits one 16-bit frame per complete scan via valid/ready. Used as on-board
//  loopback checker of the display driver and as bench monitor.
// PARAMETERS
//  SETTLE_CYC  16      consecutive stable cycles (anode+segments) required before sampling
//  TIMEOUT_CYC 2**20   max cycles without anode change before stall flag (SSCAP_TIMEOUT_EN only)
//  SYNC_STAGES 2       synchronizer depth on an/seg inputs (>=2)
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-low reset
//  an           in   4   anode selects {an3,an2,an1,an0}, active-low
//  seg          in   8   {a,b,c,d,e,f,g,dp}, active-low
//  frame_data   out  16  {char3,char2,char1,char0}, char3 = digit an3
//  frame_dp     out  4   captured dp per digit, 1 = dp lit
//  frame_valid  out  1   frame available; held until accepted
//  frame_ready  in   1   consumer accept; transfer when valid&ready
//  glyph_err    out  1   sticky: segment pattern not in glyph table
//  sel_err      out  1   sticky: more than one anode active in a settled sample
//  overrun      out  1   sticky: scan completed while frame_valid&!frame_ready
//  stalled      out  1   level: anode unchanged > TIMEOUT_CYC (0 when macro off)
//  err_clr      in   1   synchronous clear of all sticky flags
// BEHAVIOUR
//  Reset (reset=0, async): all outputs 0, FSM=IDLE, capture mask 0, sync regs to 1 (inactive).
//  Inputs pass SYNC_STAGES flops; all decisions use synchronized copies (sa, ss).
//  FSM: IDLE   -> SETTLE when sa has >=1 bit low; stab_cnt cleared.
//       SETTLE -> stab_cnt++ while {sa,ss} equal previous cycle; any change clears cnt.
//                 At cnt==SETTLE_CYC-1: sample. Exactly one low bit k: char[k]<=decode(ss[7:1]),
//                 dp[k]<=~ss[0], mask[k]<=1. >1 low: sel_err<=1, no capture. -> HOLD.
//       HOLD   -> IDLE when sa changes (digit switch or blank); sa all-ones also -> IDLE.
//  Glyph miss: char written as 4'hF, glyph_err<=1, capture still counts.
//  Re-capture of already-masked digit overwrites it (latest sample wins).
//  mask==4'hF: frame assembled next cycle; mask cleared same cycle.
//   frame_valid=0 or accepted same cycle: load frame_data/dp, frame_valid<=1.
//   else: new frame dropped, old held, overrun<=1.
//  Latency: stable digit -> capture = SYNC_STAGES+SETTLE_CYC cycles; 4th capture -> valid +1.
//  frame_valid deasserts cycle after valid&ready unless replaced by a new frame that cycle.
//  err_clr and new error same cycle: error wins (flag stays 1).
//  stab_cnt saturates; no wrap. Mid-operation reset: partial scan discarded, mask 0.
// CONFIGURATION
//  SSCAP_TIMEOUT_EN defined: counter cleared on any sa change, saturates at TIMEOUT_CYC;
//   stalled=1 while saturated, 0 on next sa change; does not block capture.
//  Not defined: counter absent, stalled tied 0.
// STRUCTURE
//  Package sevenseg_pkg: glyph table GLYPH_0..GLYPH_F (7-bit a..g active-low, shared with
//   display-side decoder), FSM state typedef/encoding (IDLE,SETTLE,HOLD), DIGITS=4.
//  One sub-module: sevenseg_glyph_decode (comb: 7-bit pattern -> char + hit flag).
//  Synchronizer stages and FSM stay inline.
// TESTING
//  1 Scan an=1110,1101,1011,0111 w/ glyphs 1,2,3,4 each 64 cyc, ready=1 -> frame_data=16'h4321,
//    frame_valid 1 cycle after 4th capture, single valid pulse.
//  2 Digit held only SETTLE_CYC-2 cycles then switched -> no capture, mask unchanged, no frame.
//  3 an=1100 stable 64 cyc -> sel_err=1, no capture; err_clr -> sel_err=0.
//  4 seg pattern 7'b1111110 (g only) on an0 -> char0=4'hF, glyph_err=1; frame still issued.
//  5 ready=0, two full scans -> first frame held, overrun=1; ready=1 -> old frame transferred.
//  6 reset low mid-scan after 2 digits -> all outputs 0; next full scan gives correct frame;
//    with SSCAP_TIMEOUT_EN, TIMEOUT_CYC=256, an frozen 300 cyc -> stalled=1, clears on change.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment scan path: active-low glyph table,
// scan FSM encoding and frame payload layout.
package sevenseg_pkg;

    localparam int unsigned DIGITS  = 4;
    localparam int unsigned CHAR_W  = 4;
    localparam int unsigned GLYPH_W = 7;
    localparam int unsigned SEG_W   = GLYPH_W + 1;

    // {a,b,c,d,e,f,g}, 0 = segment lit
    localparam logic [GLYPH_W-1:0] GLYPH_0 = 7'b0000001;
    localparam logic [GLYPH_W-1:0] GLYPH_1 = 7'b1001111;
    localparam logic [GLYPH_W-1:0] GLYPH_2 = 7'b0010010;
    localparam logic [GLYPH_W-1:0] GLYPH_3 = 7'b0000110;
    localparam logic [GLYPH_W-1:0] GLYPH_4 = 7'b1001100;
    localparam logic [GLYPH_W-1:0] GLYPH_5 = 7'b0100100;
    localparam logic [GLYPH_W-1:0] GLYPH_6 = 7'b0100000;
    localparam logic [GLYPH_W-1:0] GLYPH_7 = 7'b0001111;
    localparam logic [GLYPH_W-1:0] GLYPH_8 = 7'b0000000;
    localparam logic [GLYPH_W-1:0] GLYPH_9 = 7'b0000100;
    localparam logic [GLYPH_W-1:0] GLYPH_A = 7'b0001000;
    localparam logic [GLYPH_W-1:0] GLYPH_B = 7'b1100000;
    localparam logic [GLYPH_W-1:0] GLYPH_C = 7'b0110001;
    localparam logic [GLYPH_W-1:0] GLYPH_D = 7'b1000010;
    localparam logic [GLYPH_W-1:0] GLYPH_E = 7'b0110000;
    localparam logic [GLYPH_W-1:0] GLYPH_F = 7'b0111000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } scan_state_e;

    typedef struct packed {
        logic [DIGITS-1:0]             dp;
        logic [DIGITS-1:0][CHAR_W-1:0] chars;
    } frame_t;

endpackage

// File: rtl/sevenseg_glyph_decode.sv
// Maps an active-low a..g pattern back to its hex character; misses decode to 4'hF.
module sevenseg_glyph_decode
    import sevenseg_pkg::*;
(
    input  logic [GLYPH_W-1:0] pattern,
    output logic [CHAR_W-1:0]  value,
    output logic               hit
);

    always_comb begin
        value = 4'hF;
        hit   = 1'b1;
        case (pattern)
            GLYPH_0: value = 4'h0;
            GLYPH_1: value = 4'h1;
            GLYPH_2: value = 4'h2;
            GLYPH_3: value = 4'h3;
            GLYPH_4: value = 4'h4;
            GLYPH_5: value = 4'h5;
            GLYPH_6: value = 4'h6;
            GLYPH_7: value = 4'h7;
            GLYPH_8: value = 4'h8;
            GLYPH_9: value = 4'h9;
            GLYPH_A: value = 4'hA;
            GLYPH_B: value = 4'hB;
            GLYPH_C: value = 4'hC;
            GLYPH_D: value = 4'hD;
            GLYPH_E: value = 4'hE;
            GLYPH_F: value = 4'hF;
            default: hit   = 1'b0;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_capture.sv
// Receive side of a 4-digit multiplexed seven-segment display: recovers one
// 16-bit frame per scan. Optional anode stall detector under SSCAP_TIMEOUT_EN.
module sevenseg_scan_capture
    import sevenseg_pkg::*;
#(
    parameter int unsigned SETTLE_CYC  = 16,
`ifdef SSCAP_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYC = 2**20,
`endif
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DIGITS-1:0]        an,
    input  logic [SEG_W-1:0]         seg,
    output logic [DIGITS*CHAR_W-1:0] frame_data,
    output logic [DIGITS-1:0]        frame_dp,
    output logic                     frame_valid,
    input  logic                     frame_ready,
    output logic                     glyph_err,
    output logic                     sel_err,
    output logic                     overrun,
    output logic                     stalled,
    input  logic                     err_clr
);

    localparam int unsigned       CNT_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [SYNC_STAGES-1:0][DIGITS-1:0] an_sync;
    logic [SYNC_STAGES-1:0][SEG_W-1:0]  seg_sync;
    logic [DIGITS-1:0] sa, sa_q;
    logic [SEG_W-1:0]  ss, ss_q;
    logic              sa_changed, changed, blank, sel_one;

    scan_state_e       state, state_next;
    logic [CNT_W-1:0]  stab_cnt;
    logic              cnt_clr, cnt_inc, sample;

    frame_t            cap;
    logic [DIGITS-1:0] mask;
    logic              mask_full, load;
    logic [CHAR_W-1:0] dec_value;
    logic              dec_hit;
    logic              glyph_set, sel_set, over_set;

    // Input synchronizers; idle level is all-ones (nothing lit)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an_sync  <= '1;
            seg_sync <= '1;
            sa_q     <= '1;
            ss_q     <= '1;
        end else begin
            an_sync  <= {an_sync[SYNC_STAGES-2:0], an};
            seg_sync <= {seg_sync[SYNC_STAGES-2:0], seg};
            sa_q     <= sa;
            ss_q     <= ss;
        end
    end

    assign sa         = an_sync[SYNC_STAGES-1];
    assign ss         = seg_sync[SYNC_STAGES-1];
    assign sa_changed = (sa != sa_q);
    assign changed    = sa_changed || (ss != ss_q);
    assign blank      = &sa;
    assign sel_one    = $onehot(~sa);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (!blank) state_next = ST_SETTLE;
            ST_SETTLE: begin
                if (blank)                               state_next = ST_IDLE;
                else if (!changed && stab_cnt == CNT_LAST) state_next = ST_HOLD;
            end
            ST_HOLD:   if (sa_changed || blank) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        sample  = 1'b0;
        case (state)
            ST_IDLE:   cnt_clr = 1'b1;
            ST_SETTLE: begin
                if (changed)                    cnt_clr = 1'b1;
                else if (stab_cnt == CNT_LAST)  sample  = 1'b1;
                else                            cnt_inc = 1'b1;
            end
            default: ;
        endcase
    end

    sevenseg_glyph_decode u_decode (
        .pattern (ss[SEG_W-1:1]),
        .value   (dec_value),
        .hit     (dec_hit)
    );

    assign mask_full = &mask;
    assign load      = mask_full && (!frame_valid || frame_ready);
    assign glyph_set = sample && sel_one && !dec_hit;
    assign sel_set   = sample && !sel_one;
    assign over_set  = mask_full && frame_valid && !frame_ready;

    // Capture store, frame handoff and sticky error flags (a new error beats err_clr)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stab_cnt    <= '0;
            cap         <= '0;
            mask        <= '0;
            frame_data  <= '0;
            frame_dp    <= '0;
            frame_valid <= 1'b0;
            glyph_err   <= 1'b0;
            sel_err     <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (cnt_clr)                           stab_cnt <= '0;
            else if (cnt_inc && stab_cnt != CNT_MAX) stab_cnt <= stab_cnt + CNT_W'(1);

            if (mask_full) mask <= '0;
            if (sample && sel_one) begin
                for (int unsigned k = 0; k < DIGITS; k++) begin
                    if (!sa[k]) begin
                        cap.chars[k] <= dec_value;
                        cap.dp[k]    <= ~ss[0];
                        mask[k]      <= 1'b1;
                    end
                end
            end

            if (load) begin
                frame_data  <= cap.chars;
                frame_dp    <= cap.dp;
                frame_valid <= 1'b1;
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end

            glyph_err <= glyph_set | (glyph_err & ~err_clr);
            sel_err   <= sel_set   | (sel_err   & ~err_clr);
            overrun   <= over_set  | (overrun   & ~err_clr);
        end
    end

`ifdef SSCAP_TIMEOUT_EN
    localparam int unsigned      TO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0]  TO_MAX = TO_W'(TIMEOUT_CYC);
    logic [TO_W-1:0] to_cnt;

    // Anode activity watchdog; purely informational, never blocks capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt  <= '0;
            stalled <= 1'b0;
        end else if (sa_changed) begin
            to_cnt  <= '0;
            stalled <= 1'b0;
        end else if (to_cnt == TO_MAX) begin
            stalled <= 1'b1;
        end else begin
            to_cnt  <= to_cnt + TO_W'(1);
        end
    end
`else
    assign stalled = 1'b0;
`endif

endmodule

// File: tb/tb_sevenseg_scan_capture.sv
// Bench for sevenseg_scan_capture: scripted and random scans against a scoreboard.
// Build with SSCAP_TIMEOUT_EN defined to exercise the stall detector.
module tb_sevenseg_scan_capture;

    localparam int SETTLE = 16;
    localparam int SYNC   = 2;
    localparam int LONG   = 64;
    localparam int MIN_CAPTURE_DWELL = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  an = 4'hF;
    logic [7:0]  seg = 8'hFF;
    logic [15:0] frame_data;
    logic [3:0]  frame_dp;
    logic        frame_valid;
    logic        frame_ready = 1'b1;
    logic        glyph_err, sel_err, overrun, stalled;
    logic        err_clr = 1'b0;

    int total = 0;
    int bad   = 0;
    int valid_cycles = 0;

    logic [19:0] got_q[$];
    logic [19:0] exp_q[$];
    logic [3:0][3:0] m_chars;
    logic [3:0]      m_dp;
    logic [3:0]      m_mask;

    sevenseg_scan_capture #(
        .SETTLE_CYC  (SETTLE),
`ifdef SSCAP_TIMEOUT_EN
        .TIMEOUT_CYC (256),
`endif
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .an          (an),
        .seg         (seg),
        .frame_data  (frame_data),
        .frame_dp    (frame_dp),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .glyph_err   (glyph_err),
        .sel_err     (sel_err),
        .overrun     (overrun),
        .stalled     (stalled),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    // Consumer-side monitor: a transfer happens on the edge after a valid&ready sample
    always @(negedge clk) begin
        if (frame_valid === 1'b1) valid_cycles++;
        if (frame_valid === 1'b1 && frame_ready === 1'b1) got_q.push_back({frame_dp, frame_data});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [6:0] glyph(input logic [3:0] c);
        case (c)
            4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;  default: return 7'b0111000;
        endcase
    endfunction

    task automatic drive_pat(input int k, input logic [6:0] pat, input logic dp, input int dwell);
        an  = ~(4'b0001 << k);
        seg = {pat, ~dp};
        repeat (dwell) @(posedge clk);
        #1;
    endtask

    task automatic drive_blank(input int dwell);
        an  = 4'hF;
        seg = 8'hFF;
        repeat (dwell) @(posedge clk);
        #1;
    endtask

    task automatic model_cap(input int k, input logic [3:0] c, input logic dp);
        m_chars[k] = c;
        m_dp[k]    = dp;
        m_mask[k]  = 1'b1;
        if (m_mask == 4'hF) begin
            exp_q.push_back({m_dp, m_chars});
            m_mask = 4'h0;
        end
    endtask

    // A digit shown long enough is captured (latest sample wins); short flashes are ignored
    task automatic visit(input int k, input logic [3:0] c, input logic dp, input int dwell);
        drive_pat(k, glyph(c), dp, dwell);
        if (dwell >= MIN_CAPTURE_DWELL) model_cap(k, c, dp);
    endtask

    task automatic clear_sb();
        got_q.delete();
        exp_q.delete();
        m_mask = 4'h0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({frame_valid, glyph_err, sel_err, overrun, stalled} !== 5'b0)
            $display("FAIL reset_flags: got %b expected 00000",
                     {frame_valid, glyph_err, sel_err, overrun, stalled});
        total++;
        if ({frame_dp, frame_data} !== 20'h0)
            $display("FAIL reset_frame: got %h expected 00000", {frame_dp, frame_data});
        if ({frame_valid, glyph_err, sel_err, overrun, stalled} !== 5'b0) bad++;
        if ({frame_dp, frame_data} !== 20'h0) bad++;
        reset = 1'b1;
        drive_blank(4);
    endtask

    task automatic test_basic_scan();
        int first;
        clear_sb();
        visit(0, 4'h1, 1'b0, LONG);
        visit(1, 4'h2, 1'b0, LONG);
        visit(2, 4'h3, 1'b0, LONG);
        valid_cycles = 0;
        first = 0;
        an  = 4'b0111;
        seg = {glyph(4'h4), 1'b1};
        for (int i = 1; i <= LONG; i++) begin
            @(negedge clk);
            if (frame_valid === 1'b1 && first == 0) first = i;
        end
        @(posedge clk); #1;
        drive_blank(8);
        total++;
        if (first < SYNC + SETTLE + 1 || first > SYNC + SETTLE + 5) begin
            bad++;
            $display("FAIL basic_latency: got %0d expected %0d..%0d", first, SYNC + SETTLE + 1, SYNC + SETTLE + 5);
        end
        total++;
        if (got_q.size() != 1) begin
            bad++;
            $display("FAIL basic_count: got %0d expected 1", got_q.size());
        end else begin
            total++;
            if (got_q[0] !== 20'h04321) begin
                bad++;
                $display("FAIL basic_frame: got %h expected 04321", got_q[0]);
            end
        end
        total++;
        if (valid_cycles != 1) begin
            bad++;
            $display("FAIL basic_pulse: got %0d valid cycles expected 1", valid_cycles);
        end
    endtask

    task automatic test_short_dwell();
        clear_sb();
        visit(0, 4'h5, 1'b1, LONG);
        visit(1, 4'h6, 1'b0, LONG);
        visit(2, 4'h7, 1'b1, LONG);
        visit(3, 4'h8, 1'b0, SETTLE - 2);
        drive_blank(40);
        total++;
        if (got_q.size() != 0) begin
            bad++;
            $display("FAIL short_no_frame: got %0d frames expected 0", got_q.size());
        end
        visit(3, 4'h9, 1'b0, LONG);
        drive_blank(10);
        total++;
        if (got_q.size() != 1) begin
            bad++;
            $display("FAIL short_resume_count: got %0d expected 1", got_q.size());
        end else begin
            total++;
            if (got_q[0] !== {4'b0101, 16'h9765}) begin
                bad++;
                $display("FAIL short_resume_frame: got %h expected 59765", got_q[0]);
            end
        end
    endtask

    task automatic test_sel_err();
        clear_sb();
        an  = 4'b1100;
        seg = {glyph(4'h8), 1'b1};
        repeat (LONG) @(posedge clk);
        #1;
        drive_blank(10);
        total++;
        if (sel_err !== 1'b1) begin
            bad++;
            $display("FAIL sel_set: got %b expected 1", sel_err);
        end
        total++;
        if (got_q.size() != 0 || glyph_err !== 1'b0) begin
            bad++;
            $display("FAIL sel_no_capture: got frames=%0d glyph_err=%b expected 0/0", got_q.size(), glyph_err);
        end
        pulse_clr();
        total++;
        if (sel_err !== 1'b0) begin
            bad++;
            $display("FAIL sel_clear: got %b expected 0", sel_err);
        end
    endtask

    task automatic test_glyph_miss();
        clear_sb();
        drive_pat(0, 7'b1111110, 1'b0, LONG);
        visit(1, 4'hA, 1'b0, LONG);
        visit(2, 4'hB, 1'b0, LONG);
        visit(3, 4'hC, 1'b0, LONG);
        drive_blank(10);
        total++;
        if (glyph_err !== 1'b1) begin
            bad++;
            $display("FAIL glyph_set: got %b expected 1", glyph_err);
        end
        total++;
        if (got_q.size() != 1) begin
            bad++;
            $display("FAIL glyph_count: got %0d expected 1", got_q.size());
        end else begin
            total++;
            if (got_q[0] !== 20'h0CBAF) begin
                bad++;
                $display("FAIL glyph_frame: got %h expected 0CBAF", got_q[0]);
            end
        end
        pulse_clr();
        total++;
        if (glyph_err !== 1'b0) begin
            bad++;
            $display("FAIL glyph_clear: got %b expected 0", glyph_err);
        end
    endtask

    task automatic test_overrun();
        logic [3:0][3:0] c1, c2;
        logic [3:0]      d1, d2;
        logic [19:0]     e1;
        clear_sb();
        for (int k = 0; k < 4; k++) begin
            c1[k] = 4'($urandom_range(0, 15));
            c2[k] = 4'($urandom_range(0, 15));
        end
        d1 = 4'($urandom_range(0, 15));
        d2 = 4'($urandom_range(0, 15));
        e1 = {d1, c1};
        frame_ready = 1'b0;
        for (int k = 0; k < 4; k++) visit(k, c1[k], d1[k], LONG);
        for (int k = 0; k < 4; k++) visit(k, c2[k], d2[k], LONG);
        drive_blank(10);
        total++;
        if (frame_valid !== 1'b1 || {frame_dp, frame_data} !== e1) begin
            bad++;
            $display("FAIL overrun_held: got valid=%b frame=%h expected valid=1 frame=%h",
                     frame_valid, {frame_dp, frame_data}, e1);
        end
        total++;
        if (overrun !== 1'b1) begin
            bad++;
            $display("FAIL overrun_flag: got %b expected 1", overrun);
        end
        total++;
        if (got_q.size() != 0) begin
            bad++;
            $display("FAIL overrun_early: got %0d transfers expected 0", got_q.size());
        end
        frame_ready = 1'b1;
        drive_blank(4);
        total++;
        if (got_q.size() != 1 || got_q[0] !== e1) begin
            bad++;
            $display("FAIL overrun_drain: got %0d transfers first=%h expected 1 of %h",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 20'h0, e1);
        end
        total++;
        if (frame_valid !== 1'b0) begin
            bad++;
            $display("FAIL overrun_release: got valid=%b expected 0", frame_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0][3:0] c;
        logic [3:0]      d;
        clear_sb();
        visit(0, 4'hE, 1'b1, LONG);
        visit(1, 4'hD, 1'b1, LONG);
        #3;
        reset = 1'b0;
        #1;
        total++;
        if ({frame_valid, glyph_err, sel_err, overrun, stalled} !== 5'b0 || {frame_dp, frame_data} !== 20'h0) begin
            bad++;
            $display("FAIL midreset_outputs: got flags=%b frame=%h expected all 0",
                     {frame_valid, glyph_err, sel_err, overrun, stalled}, {frame_dp, frame_data});
        end
        an  = 4'hF;
        seg = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        clear_sb();
        for (int k = 0; k < 4; k++) c[k] = 4'($urandom_range(0, 15));
        d = 4'($urandom_range(0, 15));
        visit(2, c[2], d[2], LONG);
        visit(3, c[3], d[3], LONG);
        drive_blank(20);
        total++;
        if (got_q.size() != 0) begin
            bad++;
            $display("FAIL midreset_partial: got %0d frames expected 0", got_q.size());
        end
        visit(0, c[0], d[0], LONG);
        visit(1, c[1], d[1], LONG);
        drive_blank(10);
        total++;
        if (got_q.size() != 1 || got_q[0] !== {d, c}) begin
            bad++;
            $display("FAIL midreset_frame: got %0d frames first=%h expected 1 of %h",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 20'h0, {d, c});
        end
    endtask

    task automatic test_random();
        int prev = -1;
        int k, dwell, n;
        logic [3:0] c;
        logic       dp;
        clear_sb();
        for (int v = 0; v < 40; v++) begin
            do k = int'($urandom_range(0, 3)); while (k == prev);
            c  = 4'($urandom_range(0, 15));
            dp = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) dwell = int'($urandom_range(2, SETTLE - 2));
            else                           dwell = int'($urandom_range(MIN_CAPTURE_DWELL, 80));
            visit(k, c, dp, dwell);
            prev = k;
        end
        drive_blank(20);
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL random_count: got %0d frames expected %0d", got_q.size(), exp_q.size());
        end
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL random_frame[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_timeout();
        visit(0, 4'h1, 1'b0, 300);
`ifdef SSCAP_TIMEOUT_EN
        total++;
        if (stalled !== 1'b1) begin
            bad++;
            $display("FAIL stall_set: got %b expected 1", stalled);
        end
`else
        total++;
        if (stalled !== 1'b0) begin
            bad++;
            $display("FAIL stall_tied: got %b expected 0", stalled);
        end
`endif
        visit(1, 4'h2, 1'b0, 6);
        total++;
        if (stalled !== 1'b0) begin
            bad++;
            $display("FAIL stall_clear: got %b expected 0", stalled);
        end
        drive_blank(10);
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_short_dwell();
        test_sel_err();
        test_glyph_miss();
        test_overrun();
        test_reset_mid();
        test_random();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
